// File: rtl/child_resp_pkg.sv
// ----------------------------------------------------------------------------
// child_resp_pkg
// Shared definitions for the child response collector:
//   state_t     - collector FSM state encoding (IDLE, COLLECT, DRAIN, DONE)
//   SRC_ID_W    - width of the source channel id carried in each output word
//   src_id_t    - source id type
//   out_word_t  - output word layout {src_id, payload} at the default
//                 16-bit payload width; the top builds the same layout for
//                 any DATA_W as {src_id_t, payload}.
// ----------------------------------------------------------------------------
package child_resp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam int SRC_ID_W   = 3;
    localparam int DEF_DATA_W = 16;

    typedef logic [SRC_ID_W-1:0] src_id_t;

    typedef struct packed {
        src_id_t                src_id;
        logic [DEF_DATA_W-1:0]  payload;
    } out_word_t;

endpackage

// File: rtl/child_resp_fifo.sv
// ----------------------------------------------------------------------------
// child_resp_fifo
// Synchronous FIFO buffering collected words toward the upstream port.
// Parameters:
//   WIDTH  - word width
//   DEPTH  - number of entries, power of 2 and at least 2
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset (empties the FIFO)
//   i_push       - write i_data (ignored while full)
//   i_data       - write data
//   i_pop        - discard the head word (ignored while empty)
//   o_data       - head word, forced to zero while empty
//   o_full       - no free entry
//   o_empty      - no stored entry
//   o_count      - number of stored entries
// ----------------------------------------------------------------------------
module child_resp_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_push;
    logic w_pop;

    assign w_push = i_push && (r_count != FULL_CNT);
    assign w_pop  = i_pop  && (r_count != '0);

    // Storage carries no reset; the empty flag masks stale contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // DEPTH is a power of 2, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/child_resp_collector.sv
// ----------------------------------------------------------------------------
// child_resp_collector
// Collects one response from each channel selected in a sweep, using a
// round-robin arbiter, and forwards them upstream through an output FIFO as
// {source id, payload} words.
//
// Parameters: NUM_CH (2..8), DATA_W, FIFO_DEPTH (power of 2).
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   sweep_start   - one-cycle pulse starting a sweep (honoured only in IDLE)
//   ch_mask       - channels to collect, sampled with sweep_start
//   ch_valid      - per-channel response valid
//   ch_data       - per-channel payload, channel i at [i*DATA_W +: DATA_W]
//   ch_ready      - per-channel accept, one-hot or zero
//   out_valid     - upstream word valid (FIFO not empty)
//   out_ready     - upstream accept
//   out_data      - {source id[2:0], payload}
//   sweep_done    - one-cycle pulse when the sweep has fully drained
//   busy          - FSM not in IDLE
//   perf_words    - (CHILD_RESP_COLLECTOR_PERF_EN only) saturating count of
//                   upstream transfers since reset
//   perf_stall    - (CHILD_RESP_COLLECTOR_PERF_EN only) saturating count of
//                   cycles with out_valid && !out_ready
//
// Handshake: a word moves on any port in a cycle where its valid and ready
// are both high at the rising edge; the source holds valid and data steady
// until that happens, and ready may depend combinationally on valid.
//
// Optional feature macro: CHILD_RESP_COLLECTOR_PERF_EN
// ----------------------------------------------------------------------------
module child_resp_collector
    import child_resp_pkg::*;
#(
    parameter int NUM_CH     = 5,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        sweep_start,
    input  logic [NUM_CH-1:0]           ch_mask,
    input  logic [NUM_CH-1:0]           ch_valid,
    input  logic [NUM_CH*DATA_W-1:0]    ch_data,
    output logic [NUM_CH-1:0]           ch_ready,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W+SRC_ID_W-1:0]  out_data,
    output logic                        sweep_done,
    output logic                        busy
`ifdef CHILD_RESP_COLLECTOR_PERF_EN
    ,
    output logic [15:0]                 perf_words,
    output logic [15:0]                 perf_stall
`endif
);

    localparam int PTR_W  = $clog2(NUM_CH);
    localparam int WORD_W = DATA_W + SRC_ID_W;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    state_t              r_state;
    state_t              w_next;
    logic [NUM_CH-1:0]   r_pending;
    logic [PTR_W-1:0]    r_ptr;

    logic [NUM_CH-1:0]   w_req;
    logic                w_gnt_found;
    logic [PTR_W-1:0]    w_gnt_idx;
    logic [PTR_W:0]      w_scan_sum;
    logic [PTR_W-1:0]    w_scan;
    logic [NUM_CH-1:0]   w_ready;
    logic [NUM_CH-1:0]   w_clr;
    logic                w_xfer;
    logic [DATA_W-1:0]   w_payload;
    logic [WORD_W-1:0]   w_push_word;

    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [CNT_W-1:0]    w_fifo_count;
    logic                w_pop;

    // ------------------------------------------------------------------
    // Round-robin arbiter: r_ptr is the first index searched, so after a
    // grant to channel g the next search begins at g+1 (wrapping).
    // ------------------------------------------------------------------
    assign w_req = r_pending & ch_valid;

    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        w_scan_sum  = '0;
        w_scan      = '0;
        for (int off = 0; off < NUM_CH; off++) begin
            w_scan_sum = {1'b0, r_ptr} + (PTR_W+1)'(off);
            if (w_scan_sum >= (PTR_W+1)'(NUM_CH)) begin
                w_scan_sum = w_scan_sum - (PTR_W+1)'(NUM_CH);
            end
            w_scan = w_scan_sum[PTR_W-1:0];
            if (!w_gnt_found && w_req[w_scan]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = w_scan;
            end
        end
    end

    // A full FIFO withholds ready, so push and pop never coincide when full.
    always_comb begin
        w_ready = '0;
        if ((r_state == ST_COLLECT) && w_gnt_found && !w_fifo_full) begin
            w_ready[w_gnt_idx] = 1'b1;
        end
    end

    assign ch_ready = w_ready;
    assign w_clr    = w_ready & ch_valid;
    assign w_xfer   = |w_clr;

    always_comb begin
        w_payload = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (PTR_W'(i) == w_gnt_idx) begin
                w_payload = ch_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_push_word = {src_id_t'(w_gnt_idx), w_payload};

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    assign w_pop     = out_valid && out_ready;
    assign out_valid = !w_fifo_empty;

    child_resp_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_xfer),
        .i_data  (w_push_word),
        .i_pop   (w_pop),
        .o_data  (out_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // ------------------------------------------------------------------
    // Sweep FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (sweep_start) begin
                    w_next = (|ch_mask) ? ST_COLLECT : ST_DONE;
                end
            end
            ST_COLLECT: begin
                if ((r_pending & ~w_clr) == '0) begin
                    w_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Leave as soon as the last word is being popped so that
                // sweep_done follows the final upstream transfer directly.
                if (w_fifo_empty || ((w_fifo_count == CNT_W'(1)) && w_pop)) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_pending <= '0;
            r_ptr     <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == ST_IDLE) && sweep_start) begin
                r_pending <= ch_mask;
            end else begin
                r_pending <= r_pending & ~w_clr;
            end
            if (w_xfer) begin
                r_ptr <= (w_gnt_idx == PTR_W'(NUM_CH-1)) ? '0 : w_gnt_idx + 1'b1;
            end
        end
    end

    assign busy       = (r_state != ST_IDLE);
    assign sweep_done = (r_state == ST_DONE);

`ifdef CHILD_RESP_COLLECTOR_PERF_EN
    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    logic [15:0] r_perf_words;
    logic [15:0] r_perf_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_words <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_pop && (r_perf_words != 16'hFFFF)) begin
                r_perf_words <= r_perf_words + 16'd1;
            end
            if (out_valid && !out_ready && (r_perf_stall != 16'hFFFF)) begin
                r_perf_stall <= r_perf_stall + 16'd1;
            end
        end
    end

    assign perf_words = r_perf_words;
    assign perf_stall = r_perf_stall;
`endif

endmodule

// File: tb/tb_child_resp_collector.sv
// ----------------------------------------------------------------------------
// tb_child_resp_collector
// Directed bench for child_resp_collector (NUM_CH=5, DATA_W=16, FIFO_DEPTH=4).
// Each scenario task drives a sweep, gathers upstream words and compares them
// against hand-computed expectations held in exp_q.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_child_resp_collector;

    localparam int NUM_CH     = 5;
    localparam int DATA_W     = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int WORD_W     = DATA_W + 3;

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     sweep_start = 1'b0;
    logic [NUM_CH-1:0]        ch_mask = '0;
    logic [NUM_CH-1:0]        ch_valid = '0;
    logic [NUM_CH*DATA_W-1:0] ch_data = '0;
    logic [NUM_CH-1:0]        ch_ready;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
    logic [WORD_W-1:0]        out_data;
    logic                     sweep_done;
    logic                     busy;
`ifdef CHILD_RESP_COLLECTOR_PERF_EN
    logic [15:0]              perf_words;
    logic [15:0]              perf_stall;
`endif

    always #5 clk = ~clk;

    child_resp_collector #(
        .NUM_CH     (NUM_CH),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sweep_start (sweep_start),
        .ch_mask     (ch_mask),
        .ch_valid    (ch_valid),
        .ch_data     (ch_data),
        .ch_ready    (ch_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .sweep_done  (sweep_done),
        .busy        (busy)
`ifdef CHILD_RESP_COLLECTOR_PERF_EN
        ,
        .perf_words  (perf_words),
        .perf_stall  (perf_stall)
`endif
    );

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    int                n_vec = 0;
    int                n_err = 0;
    logic [WORD_W-1:0] exp_q[$];
    logic [WORD_W-1:0] got_q[$];
    int                first_valid_cyc;
    int                last_pop_cyc;
    int                done_cyc;
    int                stall_xfers;
    logic              bad_ready;
    logic              unstable;
    logic              saw_valid;

    function automatic logic [WORD_W-1:0] exp_word(input int id, input logic [15:0] base);
        logic [2:0]  id3;
        logic [15:0] pay;
        id3 = 3'(id);
        pay = base + 16'(id);
        return {id3, pay};
    endfunction

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic set_data(input logic [15:0] base);
        for (int i = 0; i < NUM_CH; i++) begin
            ch_data[i*DATA_W +: DATA_W] = base + 16'(i);
        end
    endtask

    // Runs one sweep with every channel valid. out_ready is low for cycles
    // before 'stall'; sweep_start is re-asserted (mask all) from cycle 'poke'
    // on when poke >= 0. Cycle 0 is the cycle carrying the first sweep_start.
    task automatic drive_sweep(input logic [NUM_CH-1:0] mask, input int stall, input int poke);
        logic              hold_valid;
        logic [WORD_W-1:0] hold_data;
        got_q.delete();
        first_valid_cyc = -1;
        last_pop_cyc    = -1;
        done_cyc        = -1;
        stall_xfers     = 0;
        bad_ready       = 1'b0;
        unstable        = 1'b0;
        saw_valid       = 1'b0;
        hold_valid      = 1'b0;
        hold_data       = '0;
        @(negedge clk);
        sweep_start = 1'b1;
        ch_mask     = mask;
        ch_valid    = '1;
        out_ready   = (0 >= stall);
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (cyc > 0) begin
                @(negedge clk);
                sweep_start = (poke >= 0) && (cyc >= poke);
                ch_mask     = (cyc > 0) ? '1 : mask;
                out_ready   = (cyc >= stall);
            end
            #1;
            if (((ch_ready & ~mask) != '0) || !$onehot0(ch_ready)) bad_ready = 1'b1;
            if ((cyc < stall) && ((ch_ready & ch_valid) != '0)) stall_xfers++;
            if (hold_valid && (out_data !== hold_data)) unstable = 1'b1;
            hold_valid = out_valid && !out_ready;
            hold_data  = out_data;
            if (out_valid) begin
                saw_valid = 1'b1;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                last_pop_cyc = cyc;
            end
            if (sweep_done) begin
                done_cyc = cyc;
                break;
            end
        end
        @(negedge clk);
        sweep_start = 1'b0;
        ch_mask     = '0;
        ch_valid    = '0;
        out_ready   = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_vec++; if (ch_ready !== '0)   begin n_err++; $display("FAIL rst_ch_ready: got %b want 0", ch_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_vec++; if (out_data !== '0)   begin n_err++; $display("FAIL rst_out_data: got %h want 0", out_data); end
        n_vec++; if (sweep_done !== 1'b0) begin n_err++; $display("FAIL rst_sweep_done: got %b want 0", sweep_done); end
        n_vec++; if (busy !== 1'b0)     begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL post_rst_busy: got %b want 0", busy); end
    endtask

    task automatic test_full_sweep();
        set_data(16'h1000);
        exp_q.delete();
        for (int i = 0; i < 5; i++) exp_q.push_back(exp_word(i, 16'h1000));
        drive_sweep(5'b11111, 0, -1);
        n_vec++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL full_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            n_vec++; if (got_q[k] !== exp_q[k]) begin n_err++; $display("FAIL full_word%0d: got %h want %h", k, got_q[k], exp_q[k]); end
        end
        n_vec++; if (first_valid_cyc != 2) begin n_err++; $display("FAIL full_latency: got cycle %0d want 2", first_valid_cyc); end
        n_vec++; if (done_cyc != 7) begin n_err++; $display("FAIL full_done_cyc: got %0d want 7", done_cyc); end
        n_vec++; if (done_cyc != last_pop_cyc + 1) begin n_err++; $display("FAIL full_done_gap: got done %0d last pop %0d want gap 1", done_cyc, last_pop_cyc); end
        n_vec++; if (bad_ready !== 1'b0) begin n_err++; $display("FAIL full_ready_rule: got %b want 0", bad_ready); end
    endtask

    // Arbiter pointer is 0 here (last grant was channel 4).
    task automatic test_mask_sweep();
        set_data(16'h2000);
        exp_q.delete();
        exp_q.push_back(exp_word(0, 16'h2000));
        exp_q.push_back(exp_word(2, 16'h2000));
        drive_sweep(5'b00101, 0, -1);
        n_vec++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL mask_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            n_vec++; if (got_q[k] !== exp_q[k]) begin n_err++; $display("FAIL mask_word%0d: got %h want %h", k, got_q[k], exp_q[k]); end
        end
        n_vec++; if (bad_ready !== 1'b0) begin n_err++; $display("FAIL mask_ready_rule: got %b want 0", bad_ready); end
        n_vec++; if (done_cyc != 4) begin n_err++; $display("FAIL mask_done_cyc: got %0d want 4", done_cyc); end
    endtask

    // Pointer is 3 now, so the order wraps: 3,4,0,1,2.
    task automatic test_backpressure();
        set_data(16'h3000);
        exp_q.delete();
        exp_q.push_back(exp_word(3, 16'h3000));
        exp_q.push_back(exp_word(4, 16'h3000));
        exp_q.push_back(exp_word(0, 16'h3000));
        exp_q.push_back(exp_word(1, 16'h3000));
        exp_q.push_back(exp_word(2, 16'h3000));
        drive_sweep(5'b11111, 10, -1);
        n_vec++; if (stall_xfers != 4) begin n_err++; $display("FAIL stall_buffered: got %0d want 4", stall_xfers); end
        n_vec++; if (unstable !== 1'b0) begin n_err++; $display("FAIL stall_data_stable: got %b want 0", unstable); end
        n_vec++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL stall_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            n_vec++; if (got_q[k] !== exp_q[k]) begin n_err++; $display("FAIL stall_word%0d: got %h want %h", k, got_q[k], exp_q[k]); end
        end
        n_vec++; if (done_cyc != 15) begin n_err++; $display("FAIL stall_done_cyc: got %0d want 15", done_cyc); end
        n_vec++; if (bad_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready_rule: got %b want 0", bad_ready); end
    endtask

    task automatic test_zero_mask();
        drive_sweep(5'b00000, 0, -1);
        n_vec++; if (done_cyc != 1) begin n_err++; $display("FAIL zero_done_cyc: got %0d want 1", done_cyc); end
        n_vec++; if (saw_valid !== 1'b0) begin n_err++; $display("FAIL zero_out_valid: got %b want 0", saw_valid); end
        n_vec++; if (bad_ready !== 1'b0) begin n_err++; $display("FAIL zero_ready_rule: got %b want 0", bad_ready); end
    endtask

    // sweep_start is held high through DRAIN and DONE; both must ignore it.
    task automatic test_ignore_start();
        logic stray;
        set_data(16'h4000);
        exp_q.delete();
        exp_q.push_back(exp_word(0, 16'h4000));
        drive_sweep(5'b00001, 0, 2);
        n_vec++; if (got_q.size() != 1) begin n_err++; $display("FAIL ignore_count: got %0d want 1", got_q.size()); end
        if (got_q.size() >= 1) begin
            n_vec++; if (got_q[0] !== exp_q[0]) begin n_err++; $display("FAIL ignore_word: got %h want %h", got_q[0], exp_q[0]); end
        end
        n_vec++; if (done_cyc != 3) begin n_err++; $display("FAIL ignore_done_cyc: got %0d want 3", done_cyc); end
        stray = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (busy || out_valid || sweep_done) stray = 1'b1;
            @(negedge clk);
        end
        n_vec++; if (stray !== 1'b0) begin n_err++; $display("FAIL ignore_idle: got activity %b want 0", stray); end
    endtask

    task automatic test_reset_mid_sweep();
        logic stray;
        set_data(16'h5000);
        @(negedge clk);
        sweep_start = 1'b1;
        ch_mask     = '1;
        ch_valid    = '1;
        out_ready   = 1'b0;
        @(negedge clk);
        sweep_start = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL mid_pre_valid: got %b want 1", out_valid); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (ch_ready !== '0)    begin n_err++; $display("FAIL mid_ch_ready: got %b want 0", ch_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
        n_vec++; if (out_data !== '0)    begin n_err++; $display("FAIL mid_out_data: got %h want 0", out_data); end
        n_vec++; if (busy !== 1'b0)      begin n_err++; $display("FAIL mid_busy: got %b want 0", busy); end
        ch_valid = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stray = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (sweep_done || busy || out_valid) stray = 1'b1;
            @(negedge clk);
        end
        n_vec++; if (stray !== 1'b0) begin n_err++; $display("FAIL mid_no_done: got activity %b want 0", stray); end
        set_data(16'h6000);
        exp_q.delete();
        for (int i = 0; i < 5; i++) exp_q.push_back(exp_word(i, 16'h6000));
        drive_sweep(5'b11111, 0, -1);
        n_vec++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL mid_fresh_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            n_vec++; if (got_q[k] !== exp_q[k]) begin n_err++; $display("FAIL mid_fresh_word%0d: got %h want %h", k, got_q[k], exp_q[k]); end
        end
    endtask

`ifdef CHILD_RESP_COLLECTOR_PERF_EN
    // Three words, out_ready low until cycle 9: words valid from cycle 2,
    // so cycles 2..8 are the seven stalled cycles.
    task automatic test_perf();
        set_data(16'h7000);
        drive_sweep(5'b00111, 9, -1);
        n_vec++; if (done_cyc != 12) begin n_err++; $display("FAIL perf_done_cyc: got %0d want 12", done_cyc); end
        n_vec++; if (perf_words !== 16'd3) begin n_err++; $display("FAIL perf_words: got %0d want 3", perf_words); end
        n_vec++; if (perf_stall !== 16'd7) begin n_err++; $display("FAIL perf_stall: got %0d want 7", perf_stall); end
        // Reset restores counters and the arbiter pointer for later scenarios.
        rst_n = 1'b0;
        #1;
        n_vec++; if (perf_words !== 16'd0) begin n_err++; $display("FAIL perf_rst_words: got %0d want 0", perf_words); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask
`endif

    // ------------------------------------------------------------------
    // Sequence and final report
    // ------------------------------------------------------------------
    initial begin
        test_reset();
`ifdef CHILD_RESP_COLLECTOR_PERF_EN
        test_perf();
`endif
        test_full_sweep();
        test_mask_sweep();
        test_backpressure();
        test_zero_mask();
        test_ignore_start();
        test_reset_mid_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/child_resp_collector.md
CHILD_RESP_COLLECTOR -- requirements
Module: child_resp_collector

Interface
REQ-001 SHALL have parameter NUM_CH, default 5, number of child response channels (2..8).
REQ-002 SHALL have parameter DATA_W, default 16, response payload width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, output FIFO entries (power of 2).
REQ-004 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port sweep_start  input  1  one-cycle pulse that begins a collection sweep.
REQ-007 SHALL have port ch_mask  input  NUM_CH  channels to collect in this sweep, sampled on sweep_start.
REQ-008 SHALL have port ch_valid  input  NUM_CH  per-channel response valid.
REQ-009 SHALL have port ch_data  input  NUM_CH*DATA_W  per-channel payload, channel i at bits [i*DATA_W +: DATA_W].
REQ-010 SHALL have port ch_ready  output  NUM_CH  per-channel accept, one-hot or zero.
REQ-011 SHALL have port out_valid  output  1  upstream word valid.
REQ-012 SHALL have port out_ready  input  1  upstream accept.
REQ-013 SHALL have port out_data  output  DATA_W+3  {source id[2:0], payload}.
REQ-014 SHALL have port sweep_done  output  1  one-cycle pulse when sweep fully drained.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM IDLE, COLLECT, DRAIN, DONE.
REQ-017 IDLE -> COLLECT on sweep_start with ch_mask nonzero; ch_mask latched into pending register.
REQ-018 sweep_start with ch_mask == 0 SHALL go IDLE -> DONE directly.
REQ-019 sweep_start outside IDLE SHALL be ignored.
REQ-020 In COLLECT, round-robin arbiter SHALL grant one pending channel with ch_valid high, starting search after last granted index, wrapping NUM_CH-1 -> 0.
REQ-021 ch_ready[i] SHALL be high only if channel i pending, granted, and FIFO not full; transfer occurs when ch_valid[i] && ch_ready[i].
REQ-022 On transfer, pending[i] SHALL clear same edge, FIFO write occurs same edge; each channel collected at most once per sweep.
REQ-023 Non-pending channels SHALL never see ch_ready high, regardless of ch_valid.
REQ-024 COLLECT -> DRAIN when pending becomes zero; DRAIN -> DONE when FIFO empty and no output transfer pending.
REQ-025 DONE SHALL assert sweep_done for exactly one cycle and return to IDLE.
REQ-026 Output FIFO: out_valid = not empty; pop on out_valid && out_ready; simultaneous push and pop when full SHALL NOT be allowed (full blocks ch_ready); simultaneous push/pop when not full SHALL keep count unchanged.
REQ-027 out_data SHALL be stable while out_valid && !out_ready.
REQ-028 Latency: word accepted at edge N SHALL appear on out_valid at cycle N+1 if FIFO was empty.

Reset
REQ-029 On rst_n low: state IDLE, pending 0, arbiter pointer 0, FIFO empty; ch_ready 0, out_valid 0, out_data 0, sweep_done 0, busy 0.
REQ-030 Reset mid-sweep SHALL discard FIFO contents and pending channels; no sweep_done after release.

Configuration
REQ-031 Macro CHILD_RESP_COLLECTOR_PERF_EN SHALL, when defined, add outputs perf_words (16 bit, saturating count of output transfers since reset) and perf_stall (16 bit, saturating count of cycles with out_valid && !out_ready); undefined, these ports and counters SHALL be absent and behaviour otherwise identical.

Structure
REQ-032 Package child_resp_pkg SHALL hold FSM state enum, source-id width constant (3), and output word typedef.
REQ-033 FIFO SHALL be a sub-module child_resp_fifo (parameters WIDTH, DEPTH; push/pop/full/empty).

Verification
REQ-034 sweep_start, ch_mask=5'b11111, all ch_valid high, out_ready high -> five words ids 0,1,2,3,4 in order, sweep_done 1 cycle after last pop.
REQ-035 ch_mask=5'b00101, all valid -> only ids 0 and 2 output; ch_ready[1,3,4] never high.
REQ-036 out_ready low for 10 cycles, mask all -> 4 words buffered, ch_ready all 0 while full, out_data stable; release -> remaining word accepted, 5 total.
REQ-037 ch_mask=0 -> sweep_done 1 cycle after sweep_start, no out_valid.
REQ-038 Reset asserted after 2 of 5 transfers -> all outputs 0 immediately; new sweep afterwards yields 5 fresh words.
REQ-039 PERF_EN defined, 3 words with 7 stall cycles -> perf_words=3, perf_stall=7.
